// File: rtl/mdc_out_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : mdc_out_stream_packer
// Purpose  : Buffers MDC network output words and re-emits them as an
//            AXI4-Stream packet of programmable length with TLAST framing.
// Revision : 1.0 - initial release
// ============================================================================
module mdc_out_stream_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_wr,
    output logic                  in_full,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam int                 c_ADDR_W    = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0]  c_DEPTH_CNT = (c_ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_ADDR_W-1:0]   r_wr_ptr;
    logic [c_ADDR_W-1:0]   r_rd_ptr;
    logic [c_ADDR_W:0]     r_count;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_in_cnt;
    logic [LEN_WIDTH-1:0]  r_out_cnt;

    logic w_run;
    logic w_full;
    logic w_valid;
    logic w_last;
    logic w_wr_en;
    logic w_rd_en;

    // All flow-control terms come from registered state only, so the
    // producer never sees a combinational path from its own strobe.
    assign w_run   = (r_state == S_RUN);
    assign w_full  = !w_run || (r_count == c_DEPTH_CNT) || (r_in_cnt == r_len);
    assign w_valid = w_run && (r_count != '0);
    assign w_last  = w_valid && (r_out_cnt == (r_len - LEN_WIDTH'(1)));
    assign w_wr_en = in_wr && !w_full;
    assign w_rd_en = w_valid && m_axis_tready;

    assign in_full       = w_full;
    assign m_axis_tvalid = w_valid;
    assign m_axis_tlast  = w_last;
    assign m_axis_tdata  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign busy          = r_busy;
    assign done          = r_done;

    // Storage is not reset; validity is tracked entirely by r_count.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + (c_ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_len     <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start && (cfg_len != '0)) begin
                        r_len     <= cfg_len;
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_wr_en) begin
                        r_in_cnt <= r_in_cnt + LEN_WIDTH'(1);
                    end
                    if (w_rd_en) begin
                        r_out_cnt <= r_out_cnt + LEN_WIDTH'(1);
                    end
                    // The TLAST beat implies every accepted word has drained.
                    if (w_rd_en && w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdc_out_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdc_out_stream_packer
// Purpose  : Randomized self-checking bench against a queue-based packet model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdc_out_stream_packer;

    localparam int c_DW    = 32;
    localparam int c_DEPTH = 16;
    localparam int c_LW    = 16;

    logic              clock;
    logic              reset;
    logic [c_LW-1:0]   cfg_len;
    logic              start;
    logic              busy;
    logic              done;
    logic [c_DW-1:0]   in_data;
    logic              in_wr;
    logic              in_full;
    logic [c_DW-1:0]   m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;

    mdc_out_stream_packer #(
        .DATA_WIDTH (c_DW),
        .DEPTH      (c_DEPTH),
        .LEN_WIDTH  (c_LW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cfg_len       (cfg_len),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .in_data       (in_data),
        .in_wr         (in_wr),
        .in_full       (in_full),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Packet-level model: mode 0 idle, 1 packet open, 2 completion cycle.
    int              m_mode;
    int              m_len;
    int              m_in;
    int              m_out;
    logic [c_DW-1:0] m_q[$];
    int              beats;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_len  = 0;
        m_in   = 0;
        m_out  = 0;
        m_q.delete();
        beats  = 0;
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic tick();
        bit              ef, ev, el, acc_wr, acc_rd;
        logic [c_DW-1:0] ed;
        ef = (m_mode != 1) || (m_q.size() == c_DEPTH) || (m_in == m_len);
        ev = (m_mode == 1) && (m_q.size() != 0);
        ed = ev ? m_q[0] : '0;
        el = ev && (m_out == m_len - 1);
        chk("busy",    32'(busy),          32'(m_mode == 1));
        chk("done",    32'(done),          32'(m_mode == 2));
        chk("in_full", 32'(in_full),       32'(ef));
        chk("tvalid",  32'(m_axis_tvalid), 32'(ev));
        chk("tdata",   m_axis_tdata,       ed);
        chk("tlast",   32'(m_axis_tlast),  32'(el));
        if (m_axis_tvalid && m_axis_tready) beats++;
        if (m_mode == 2) begin
            chk("beats", 32'(beats), 32'(m_len));
            beats = 0;
        end
        acc_wr = in_wr && !ef;
        acc_rd = ev && m_axis_tready;
        case (m_mode)
            0: if (start && cfg_len != 0) begin
                m_mode = 1; m_len = int'(cfg_len); m_in = 0; m_out = 0; beats = 0;
            end
            1: begin
                if (acc_rd) begin
                    void'(m_q.pop_front());
                    m_out++;
                    if (el) m_mode = 2;
                end
                if (acc_wr) begin
                    m_q.push_back(in_data);
                    m_in++;
                end
            end
            default: m_mode = 0;
        endcase
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run_packet(input int len, input int wr_pct, input int rdy_pct,
                              input int rdy_hold, input bit seq, input bit noisy_start);
        int n;
        cfg_len = c_LW'(len);
        start   = 1'b1;
        in_wr   = 1'b0;
        m_axis_tready = 1'b0;
        tick();
        start = 1'b0;
        n = 0;
        while (m_mode != 0 && n < 3000) begin
            in_wr   = ($urandom_range(99) < wr_pct);
            in_data = seq ? (32'h10 + 32'(n)) : $urandom;
            m_axis_tready = (n >= rdy_hold) && ($urandom_range(99) < rdy_pct);
            start   = noisy_start && (m_mode == 1) && ($urandom_range(7) == 0);
            cfg_len = c_LW'($urandom_range(1, 50));
            tick();
            n++;
        end
        start = 1'b0;
        in_wr = 1'b0;
        if (m_mode != 0) begin
            chk("packet_timeout", 32'(m_mode), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        cfg_len = '0;
        start = 1'b0;
        in_data = '0;
        in_wr = 1'b0;
        m_axis_tready = 1'b0;
        model_reset();
        @(negedge clock);
        tick();
        reset = 1'b0;
        tick();

        // Basic 4-word packet with sequential data and tready always high.
        run_packet(4, 100, 100, 0, 1'b1, 1'b0);

        // Backpressure fill: 20 words against a 16-deep buffer, drain later.
        run_packet(20, 100, 100, 30, 1'b1, 1'b0);

        // Length boundary: producer keeps writing past the programmed length.
        run_packet(3, 100, 100, 0, 1'b0, 1'b0);

        // Degenerate start: zero length must be ignored entirely.
        cfg_len = '0;
        start   = 1'b1;
        in_wr   = 1'b1;
        tick();
        start   = 1'b0;
        repeat (3) tick();
        in_wr   = 1'b0;

        // Start requests during an open packet must not disturb it.
        run_packet(12, 70, 60, 0, 1'b0, 1'b1);

        // Asynchronous reset with five words buffered and tvalid high.
        cfg_len = 16'd8;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        m_axis_tready = 1'b0;
        in_wr   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = $urandom;
            tick();
        end
        in_wr = 1'b0;
        chk("pre_reset_tvalid", 32'(m_axis_tvalid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy",    32'(busy),          32'd0);
        chk("arst_done",    32'(done),          32'd0);
        chk("arst_tvalid",  32'(m_axis_tvalid), 32'd0);
        chk("arst_tlast",   32'(m_axis_tlast),  32'd0);
        chk("arst_tdata",   m_axis_tdata,       32'd0);
        chk("arst_in_full", 32'(in_full),       32'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        tick();
        run_packet(4, 100, 100, 0, 1'b0, 1'b0);

        // Randomized packets with random traffic densities.
        for (int p = 0; p < 30; p++) begin
            run_packet($urandom_range(1, 40), $urandom_range(20, 100),
                       $urandom_range(20, 100), $urandom_range(0, 20), 1'b0, 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
